// File: rtl/morty_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// morty_hazard_ctrl_if : pipeline hazard inputs and stage control outputs
// Rev 1.0
// ============================================================================
interface morty_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_branch_taken;
   logic        ex_md_start;
   logic        md_done;
   logic        dmem_req;
   logic        dmem_ack;
   logic        exc_valid;
   logic        stall_pc;
   logic        stall_ifid;
   logic        clear_ifid;
   logic        stall_idex;
   logic        clear_idex;
   logic        stall_exmem;
   logic        clear_exmem;
   logic        stall_memwb;
   logic        clear_memwb;
   logic [1:0]  pc_sel;
   logic        md_abort;
   logic        mem_timeout;
   logic [31:0] stall_cycles;

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, ex_md_start, md_done, dmem_req, dmem_ack, exc_valid,
      output stall_pc, stall_ifid, clear_ifid, stall_idex, clear_idex,
             stall_exmem, clear_exmem, stall_memwb, clear_memwb, pc_sel,
             md_abort, mem_timeout, stall_cycles
   );

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, ex_md_start, md_done, dmem_req, dmem_ack, exc_valid,
      input  stall_pc, stall_ifid, clear_ifid, stall_idex, clear_idex,
             stall_exmem, clear_exmem, stall_memwb, clear_memwb, pc_sel,
             md_abort, mem_timeout, stall_cycles
   );
endinterface
`default_nettype wire

// File: rtl/morty_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// morty_hazard_ctrl : stall/clear/next-PC sequencer for the 5-stage core
// Rev 1.0
// ============================================================================
module morty_hazard_ctrl #(
   parameter int TRAP_CYCLES = 2,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   morty_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MEM_WAIT = 2'd2,
      TRAP     = 2'd3
   } state_t;

   localparam logic [3:0] TRAP_LOAD = 4'(TRAP_CYCLES - 1);
   localparam logic [9:0] WAIT_LAST = 10'(MEM_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [3:0]  trap_cnt, trap_cnt_nx;
   logic [9:0]  wait_cnt, wait_cnt_nx;
   logic        md_pending, md_pending_nx;
   logic        md_done_seen, md_done_seen_nx;
   logic [31:0] stall_cnt;
   logic        load_use, md_wait_eff, md_track;
   logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic        clear_ifid, clear_idex, clear_exmem, clear_memwb;
   logic [1:0]  pc_sel;
   logic        md_abort, mem_timeout;

   assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         trap_cnt     <= '0;
         wait_cnt     <= '0;
         md_pending   <= 1'b0;
         md_done_seen <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         state        <= state_nx;
         trap_cnt     <= trap_cnt_nx;
         wait_cnt     <= wait_cnt_nx;
         md_pending   <= md_pending_nx;
         md_done_seen <= md_done_seen_nx;
         if (stall_pc) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   always_comb begin
      state_nx        = state;
      trap_cnt_nx     = trap_cnt;
      wait_cnt_nx     = '0;
      md_pending_nx   = md_pending;
      md_done_seen_nx = md_done_seen;
      md_wait_eff     = 1'b0;
      md_track        = 1'b0;
      stall_pc        = 1'b0;
      stall_ifid      = 1'b0;
      stall_idex      = 1'b0;
      stall_exmem     = 1'b0;
      clear_ifid      = 1'b0;
      clear_idex      = 1'b0;
      clear_exmem     = 1'b0;
      clear_memwb     = 1'b0;
      pc_sel          = 2'b00;
      md_abort        = 1'b0;
      mem_timeout     = 1'b0;

      if (rst) begin
         clear_ifid  = 1'b1;
         clear_idex  = 1'b1;
         clear_exmem = 1'b1;
         clear_memwb = 1'b1;
      end else if (hz.exc_valid) begin
         clear_ifid      = 1'b1;
         clear_idex      = 1'b1;
         clear_exmem     = 1'b1;
         stall_pc        = 1'b1;
         md_abort        = (state == MD_WAIT) || hz.ex_md_start;
         state_nx        = TRAP;
         trap_cnt_nx     = TRAP_LOAD;
         md_pending_nx   = 1'b0;
         md_done_seen_nx = 1'b0;
      end else if (state == TRAP) begin
         clear_ifid  = 1'b1;
         clear_idex  = 1'b1;
         clear_exmem = 1'b1;
         if (trap_cnt != 4'd0) begin
            stall_pc    = 1'b1;
            trap_cnt_nx = trap_cnt - 4'd1;
         end else begin
            pc_sel   = 2'b10;
            state_nx = RUN;
         end
      end else if (hz.dmem_req && !hz.dmem_ack) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         stall_exmem = 1'b1;
         clear_memwb = 1'b1;
         state_nx    = MEM_WAIT;
         // A mul/div already running (or just issued) keeps going underneath
         // the memory stall, so its completion must not be lost.
         if (state == MEM_WAIT) begin
            md_done_seen_nx = md_done_seen || hz.md_done;
         end else begin
            md_track        = (state == MD_WAIT) || hz.ex_md_start;
            md_pending_nx   = md_track;
            md_done_seen_nx = md_track && hz.md_done;
         end
         if (wait_cnt == WAIT_LAST) begin
            mem_timeout = 1'b1;
         end else begin
            wait_cnt_nx = wait_cnt + 10'd1;
         end
      end else begin
         state_nx        = RUN;
         md_pending_nx   = 1'b0;
         md_done_seen_nx = 1'b0;
         md_wait_eff     = (state == MD_WAIT) ||
                           ((state == MEM_WAIT) && md_pending && !md_done_seen);
         if (md_wait_eff || hz.ex_md_start) begin
            if (!hz.md_done) begin
               stall_pc    = 1'b1;
               stall_ifid  = 1'b1;
               stall_idex  = 1'b1;
               clear_exmem = 1'b1;
               state_nx    = MD_WAIT;
            end
         end else if (hz.ex_branch_taken) begin
            clear_ifid = 1'b1;
            clear_idex = 1'b1;
            pc_sel     = 2'b01;
         end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            clear_idex = 1'b1;
         end
      end
   end

   assign hz.stall_pc     = stall_pc;
   assign hz.stall_ifid   = stall_ifid;
   assign hz.clear_ifid   = clear_ifid;
   assign hz.stall_idex   = stall_idex;
   assign hz.clear_idex   = clear_idex;
   assign hz.stall_exmem  = stall_exmem;
   assign hz.clear_exmem  = clear_exmem;
   assign hz.stall_memwb  = 1'b0;
   assign hz.clear_memwb  = clear_memwb;
   assign hz.pc_sel       = pc_sel;
   assign hz.md_abort     = md_abort;
   assign hz.mem_timeout  = mem_timeout;
   assign hz.stall_cycles = stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_morty_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_morty_hazard_ctrl : randomized + directed scoreboard bench
// Rev 1.0
// ============================================================================
module tb_morty_hazard_ctrl;
   localparam int TRAP_CYCLES = 2;
   localparam int MEM_TIMEOUT = 4;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       mr, br, ms, md, dreq, dack, exc;
   } stim_t;

   // stall/clear bit order: ifid, idex, exmem, memwb
   typedef struct packed {
      logic        stall_pc;
      logic [3:0]  stall;
      logic [3:0]  clear;
      logic [1:0]  pc_sel;
      logic        md_abort;
      logic        mem_timeout;
      logic [31:0] sc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t expq[$];

   morty_hazard_ctrl_if hz();

   morty_hazard_ctrl #(.TRAP_CYCLES(TRAP_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   always #5 clk = ~clk;

   // Reference model: trap_left < 0 means no trap drain in progress.
   int          trap_left = -1;
   bit          in_mem = 0, md_busy = 0, md_pend = 0, md_seen = 0;
   int          waits = 0;
   logic [31:0] stalls = '0;

   task automatic model(input stim_t s, output exp_t e);
      bit lu, md_now, trk;
      e    = '0;
      e.sc = stalls;
      lu   = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (s.rst) begin
         e.clear = 4'hF;
         trap_left = -1; in_mem = 0; md_busy = 0; md_pend = 0; md_seen = 0;
         waits = 0; stalls = '0;
         return;
      end
      if (s.exc) begin
         e.clear    = 4'b1110;
         e.stall_pc = 1;
         e.md_abort = md_busy || s.ms;
         trap_left  = TRAP_CYCLES - 1;
         in_mem = 0; md_busy = 0; md_pend = 0; md_seen = 0; waits = 0;
      end else if (trap_left >= 0) begin
         e.clear = 4'b1110;
         if (trap_left > 0) begin
            e.stall_pc = 1;
            trap_left--;
         end else begin
            e.pc_sel  = 2'b10;
            trap_left = -1;
         end
      end else if (s.dreq && !s.dack) begin
         e.stall_pc = 1;
         e.stall    = 4'b1110;
         e.clear    = 4'b0001;
         if (in_mem) begin
            md_seen = md_seen || s.md;
         end else begin
            trk     = md_busy || s.ms;
            md_pend = trk;
            md_seen = trk && s.md;
         end
         e.mem_timeout = (waits % MEM_TIMEOUT) == (MEM_TIMEOUT - 1);
         waits++;
         in_mem  = 1;
         md_busy = 0;
      end else begin
         md_now = md_busy;
         if (in_mem) md_now = md_pend && !md_seen;
         in_mem = 0; md_pend = 0; md_seen = 0; waits = 0;
         md_busy = 0;
         if (md_now || s.ms) begin
            if (!s.md) begin
               e.stall_pc = 1;
               e.stall    = 4'b1100;
               e.clear    = 4'b0010;
               md_busy    = 1;
            end
         end else if (s.br) begin
            e.clear  = 4'b1100;
            e.pc_sel = 2'b01;
         end else if (lu) begin
            e.stall_pc = 1;
            e.stall    = 4'b1000;
            e.clear    = 4'b0100;
         end
      end
      if (e.stall_pc) stalls = stalls + 32'd1;
   endtask

   task automatic apply(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst                = s.rst;
      hz.id_rs1          = s.rs1;
      hz.id_rs2          = s.rs2;
      hz.id_use_rs1      = s.u1;
      hz.id_use_rs2      = s.u2;
      hz.ex_rd           = s.rd;
      hz.ex_mem_read     = s.mr;
      hz.ex_branch_taken = s.br;
      hz.ex_md_start     = s.ms;
      hz.md_done         = s.md;
      hz.dmem_req        = s.dreq;
      hz.dmem_ack        = s.dack;
      hz.exc_valid       = s.exc;
      model(s, e);
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      stim_t s;
      s = '0;
      for (int i = 0; i < n; i++) apply(s);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s      = '0;
      s.rst  = ($urandom_range(0, 199) == 0);
      s.exc  = ($urandom_range(0, 39) == 0);
      s.dreq = ($urandom_range(0, 2) == 0);
      s.dack = $urandom_range(0, 1) != 0;
      s.br   = ($urandom_range(0, 5) == 0);
      s.ms   = ($urandom_range(0, 9) == 0);
      s.md   = ($urandom_range(0, 3) == 0);
      s.mr   = $urandom_range(0, 1) != 0;
      s.u1   = $urandom_range(0, 1) != 0;
      s.u2   = $urandom_range(0, 1) != 0;
      s.rd   = 5'($urandom_range(0, 3));
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      return s;
   endfunction

   // Monitor: outputs are valid every cycle; compare mid-cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         cyc++;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {hz.stall_pc,
                 {hz.stall_ifid, hz.stall_idex, hz.stall_exmem, hz.stall_memwb},
                 {hz.clear_ifid, hz.clear_idex, hz.clear_exmem, hz.clear_memwb},
                 hz.pc_sel, hz.md_abort, hz.mem_timeout, hz.stall_cycles};
            tests++;
            if (a[44:32] !== e[44:32]) begin
               fails++;
               $display("FAIL ctrl cycle %0d: got %b required %b (pc,stall4,clear4,sel2,abort,tmo)",
                        cyc, a[44:32], e[44:32]);
            end
            tests++;
            if (a.sc !== e.sc) begin
               fails++;
               $display("FAIL stall_cycles cycle %0d: got %0d required %0d", cyc, a.sc, e.sc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
      hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0; hz.ex_md_start = 0;
      hz.md_done = 0; hz.dmem_req = 0; hz.dmem_ack = 0; hz.exc_valid = 0;

      s = '0; s.rst = 1;
      apply(s); apply(s);
      idle(2);

      // load-use on rs2, then the x0 case that must not stall
      s = '0; s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
      apply(s);
      idle(1);
      s = '0; s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
      apply(s);
      // branch wins over load-use
      s = '0; s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; s.br = 1;
      apply(s);

      // mul/div with done 6 cycles after start
      s = '0; s.ms = 1;
      apply(s);
      idle(5);
      s = '0; s.md = 1;
      apply(s);
      idle(1);

      // dmem wait of 3 cycles, then ack
      s = '0; s.dreq = 1;
      apply(s); apply(s); apply(s);
      s.dack = 1;
      apply(s);
      idle(1);

      // no ack: periodic timeout
      s = '0; s.dreq = 1;
      for (int i = 0; i < 10; i++) apply(s);
      idle(1);

      // exception during MD_WAIT
      s = '0; s.ms = 1;
      apply(s);
      idle(2);
      s = '0; s.exc = 1;
      apply(s);
      idle(4);

      // md in flight, dmem stall overlaps md_done, then release
      s = '0; s.ms = 1;
      apply(s);
      s = '0; s.dreq = 1;
      apply(s);
      s.md = 1;
      apply(s);
      s.md = 0;
      apply(s);
      idle(2);

      // md in flight, dmem stall, md still pending after release
      s = '0; s.ms = 1;
      apply(s);
      s = '0; s.dreq = 1;
      apply(s); apply(s);
      idle(3);
      s = '0; s.md = 1;
      apply(s);

      // reset in the middle of a memory wait
      s = '0; s.dreq = 1;
      apply(s); apply(s);
      s.rst = 1;
      apply(s);
      idle(3);

      for (int i = 0; i < 4000; i++) apply(rand_stim());
      idle(2);

      @(negedge clk);
      #1;
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d queued required 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
